// File: rtl/rotfpga2b_scan_loader.sv
// rotfpga2b_scan_loader: streams config bytes LSB-first into a scan chain, two cycles per bit, with readback
module rotfpga2b_scan_loader #(
  parameter int CHAIN_LEN = 512,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       scan_clk,
  output logic       scan_se,
  output logic       scan_sc,
  input  logic       scan_so,
  output logic       rb_valid,
  output logic [7:0] rb_data,
  output logic       busy,
  output logic       done
);
  typedef enum logic [1:0] {IDLE, LOAD, FIN} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0] byte_q, byte_d, rb_q, rb_d;
  logic [2:0] idx_q, idx_d;
  logic held_q, held_d, ph_q, ph_d, rbv_q, rbv_d;
  logic last_bit, accept;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      byte_q <= '0;
      rb_q <= '0;
      idx_q <= '0;
      held_q <= 1'b0;
      ph_q <= 1'b0;
      rbv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      byte_q <= byte_d;
      rb_q <= rb_d;
      idx_q <= idx_d;
      held_q <= held_d;
      ph_q <= ph_d;
      rbv_q <= rbv_d;
    end
  end
  always_comb begin
    busy = state_q == LOAD;
    done = state_q == FIN;
    last_bit = cnt_q == LAST;
    in_ready = busy && (!held_q || (idx_q == 3'd7 && ph_q && !last_bit));
    accept = in_ready && in_valid && !abort;
    scan_se = busy && held_q;
    scan_clk = scan_se && ph_q;
    scan_sc = scan_se && byte_q[idx_q];
    rb_valid = rbv_q;
    rb_data = rb_q;
    state_d = state_q;
    cnt_d = cnt_q;
    byte_d = byte_q;
    rb_d = rb_q;
    idx_d = idx_q;
    held_d = held_q;
    ph_d = ph_q;
    rbv_d = 1'b0;
    case (state_q)
      IDLE: if (start && !abort) begin
        state_d = LOAD;
        cnt_d = '0;
        idx_d = '0;
        held_d = 1'b0;
        ph_d = 1'b0;
      end
      LOAD: if (abort) begin
        state_d = IDLE;
        held_d = 1'b0;
        ph_d = 1'b0;
      end else if (held_q && !ph_q) begin
        // a fresh readback byte starts cleared so unsampled bits of a partial byte read as 0
        ph_d = 1'b1;
        rb_d = (idx_q == 3'd0) ? 8'h00 : rb_q;
        rb_d[idx_q] = scan_so;
        rbv_d = idx_q == 3'd7 || last_bit;
      end else if (held_q) begin
        ph_d = 1'b0;
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q + 3'd1;
        if (last_bit) begin
          state_d = FIN;
          held_d = 1'b0;
        end else if (idx_q == 3'd7) begin
          held_d = accept;
          byte_d = accept ? in_data : byte_q;
        end
      end else if (accept) begin
        held_d = 1'b1;
        byte_d = in_data;
        idx_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
